// File: rtl/eb_pkg.sv
// Shared types and elaboration helpers for the elastic-buffer width converters.
package eb_pkg;

  typedef enum logic {EB_EMPTY = 1'b0, EB_BUSY = 1'b1} eb_state_t;

  localparam int EB_MIN_RATIO = 2;

  // Beat counter width; a ratio of 2 still needs one bit.
  function automatic int eb_cnt_w(input int ratio);
    return (ratio > 2) ? $clog2(ratio) : 1;
  endfunction

  function automatic bit eb_ratio_ok(input int t_w, input int i_w);
    return (i_w > 0) && ((t_w % i_w) == 0) && ((t_w / i_w) >= EB_MIN_RATIO);
  endfunction

endpackage

// File: rtl/eb_dnsize_if.sv
// Valid/ready bundle for eb_dnsize: wide target side in, narrow initiator side out.
// i_0_last exists only when EB_DNSIZE_LAST_EN is defined.
interface eb_dnsize_if #(
  parameter int T_0_WIDTH = 32,
  parameter int I_0_WIDTH = 8
);
  logic [T_0_WIDTH-1:0] t_0_data;
  logic                 t_0_valid;
  logic                 t_0_ready;
  logic [I_0_WIDTH-1:0] i_0_data;
  logic                 i_0_valid;
  logic                 i_0_ready;
`ifdef EB_DNSIZE_LAST_EN
  logic                 i_0_last;
`endif

  modport master (
    output t_0_data, t_0_valid, i_0_ready,
    input  t_0_ready, i_0_data, i_0_valid
`ifdef EB_DNSIZE_LAST_EN
    , input i_0_last
`endif
  );

  modport slave (
    input  t_0_data, t_0_valid, i_0_ready,
    output t_0_ready, i_0_data, i_0_valid
`ifdef EB_DNSIZE_LAST_EN
    , output i_0_last
`endif
  );
endinterface

// File: rtl/eb_dnsize_ctrl.sv
// Control half of eb_dnsize: occupancy state, beat counter and handshake decode.
// With EB_DNSIZE_LAST_EN defined it also drives the word delimiter i_0_last.
module eb_dnsize_ctrl
  import eb_pkg::*;
#(
  parameter int RATIO = 4,
  parameter int CNT_W = eb_cnt_w(RATIO)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             t_0_valid,
  input  logic             i_0_ready,
  output logic             t_0_ready,
  output logic             i_0_valid,
  output logic             en_load,
  output logic [CNT_W-1:0] sel
`ifdef EB_DNSIZE_LAST_EN
  , output logic           i_0_last
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO - 1);

  eb_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             i_xfer;

  assign i_0_valid = (state == EB_BUSY);
  assign last      = i_0_valid && (cnt == CNT_MAX);
  // Ready depends only on state and i_0_ready, never on t_0_valid.
  assign t_0_ready = !i_0_valid || (last && i_0_ready);
  assign en_load   = t_0_valid && t_0_ready;
  assign i_xfer    = i_0_valid && i_0_ready;
  assign sel       = cnt;
`ifdef EB_DNSIZE_LAST_EN
  assign i_0_last  = last;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= EB_EMPTY;
      cnt   <= '0;
    end else begin
      case (state)
        EB_EMPTY: begin
          if (en_load) begin
            state <= EB_BUSY;
            cnt   <= '0;
          end
        end
        EB_BUSY: begin
          if (i_xfer) begin
            // Final beat: reload back-to-back if a new word arrives, else drain.
            if (cnt == CNT_MAX) begin
              cnt   <= '0;
              state <= en_load ? EB_BUSY : EB_EMPTY;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state <= EB_EMPTY;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/eb_dnsize.sv
// Elastic width-down converter: one T_0_WIDTH word in, RATIO I_0_WIDTH beats out, LSB first.
// Define EB_DNSIZE_LAST_EN to add the i_0_last word delimiter output.
module eb_dnsize
  import eb_pkg::*;
#(
  parameter int T_0_WIDTH = 32,
  parameter int I_0_WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  eb_dnsize_if.slave bus
);

  localparam int RATIO = T_0_WIDTH / I_0_WIDTH;
  localparam int CNT_W = eb_cnt_w(RATIO);

  if (!eb_ratio_ok(T_0_WIDTH, I_0_WIDTH)) begin : g_bad_ratio
    $error("eb_dnsize: T_0_WIDTH must be a multiple of I_0_WIDTH with at least 2 beats per word");
  end

  logic [T_0_WIDTH-1:0] hold;
  logic [I_0_WIDTH-1:0] beats [RATIO];
  logic                 en_load;
  logic [CNT_W-1:0]     sel;

  eb_dnsize_ctrl #(
    .RATIO (RATIO),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk       (clk),
    .reset_n   (reset_n),
    .t_0_valid (bus.t_0_valid),
    .i_0_ready (bus.i_0_ready),
    .t_0_ready (bus.t_0_ready),
    .i_0_valid (bus.i_0_valid),
    .en_load   (en_load),
    .sel       (sel)
`ifdef EB_DNSIZE_LAST_EN
    , .i_0_last (bus.i_0_last)
`endif
  );

  // Hold register changes only on an accepted wide word.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold <= '0;
    end else if (en_load) begin
      hold <= bus.t_0_data;
    end
  end

  for (genvar g = 0; g < RATIO; g++) begin : g_beat
    assign beats[g] = hold[g*I_0_WIDTH +: I_0_WIDTH];
  end

  assign bus.i_0_data = beats[sel];

endmodule

// File: tb/tb_eb_dnsize.sv
// Bench for eb_dnsize: directed scenarios on 32->8 and 24->8 instances plus a randomized run
// checked against a beat-queue model. Honours EB_DNSIZE_LAST_EN when defined.
module tb_eb_dnsize;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  eb_dnsize_if #(.T_0_WIDTH(32), .I_0_WIDTH(8)) a_if ();
  eb_dnsize_if #(.T_0_WIDTH(24), .I_0_WIDTH(8)) b_if ();

  eb_dnsize #(.T_0_WIDTH(32), .I_0_WIDTH(8)) u_dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (a_if.slave)
  );

  eb_dnsize #(.T_0_WIDTH(24), .I_0_WIDTH(8)) u_dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (b_if.slave)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    a_if.t_0_valid = 1'b1; a_if.t_0_data = $urandom; a_if.i_0_ready = 1'b1;
    b_if.t_0_valid = 1'b1; b_if.t_0_data = 24'h5A5A5A; b_if.i_0_ready = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_checks++; if (a_if.i_0_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_valid: got %0b expected 0", a_if.i_0_valid); end
    n_checks++; if (a_if.i_0_data !== 8'h00) begin n_fail++; $display("FAIL reset_a_data: got %h expected 00", a_if.i_0_data); end
    n_checks++; if (a_if.t_0_ready !== 1'b1) begin n_fail++; $display("FAIL reset_a_tready: got %0b expected 1", a_if.t_0_ready); end
    n_checks++; if (b_if.i_0_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b_valid: got %0b expected 0", b_if.i_0_valid); end
    n_checks++; if (b_if.i_0_data !== 8'h00) begin n_fail++; $display("FAIL reset_b_data: got %h expected 00", b_if.i_0_data); end
    n_checks++; if (b_if.t_0_ready !== 1'b1) begin n_fail++; $display("FAIL reset_b_tready: got %0b expected 1", b_if.t_0_ready); end
`ifdef EB_DNSIZE_LAST_EN
    n_checks++; if (a_if.i_0_last !== 1'b0) begin n_fail++; $display("FAIL reset_a_last: got %0b expected 0", a_if.i_0_last); end
`endif
    reset_n = 1'b1;
    a_if.t_0_valid = 1'b0;
    b_if.t_0_valid = 1'b0;
    next_cycle();
  endtask

  task automatic test_single_word();
    logic [31:0] w;
    logic [7:0]  exp;
    w = 32'hDDCCBBAA;
    a_if.i_0_ready = 1'b1; a_if.t_0_valid = 1'b1; a_if.t_0_data = w;
    @(negedge clk);
    n_checks++; if (a_if.t_0_ready !== 1'b1) begin n_fail++; $display("FAIL single_accept: got %0b expected 1", a_if.t_0_ready); end
    next_cycle();
    a_if.t_0_valid = 1'b0; a_if.t_0_data = $urandom;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp = 8'(w >> (8 * k));
      n_checks++; if (a_if.i_0_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid[%0d]: got %0b expected 1", k, a_if.i_0_valid); end
      n_checks++; if (a_if.i_0_data !== exp) begin n_fail++; $display("FAIL single_data[%0d]: got %h expected %h", k, a_if.i_0_data, exp); end
      n_checks++; if (a_if.t_0_ready !== (k == 3)) begin n_fail++; $display("FAIL single_tready[%0d]: got %0b expected %0b", k, a_if.t_0_ready, (k == 3)); end
`ifdef EB_DNSIZE_LAST_EN
      n_checks++; if (a_if.i_0_last !== (k == 3)) begin n_fail++; $display("FAIL single_last[%0d]: got %0b expected %0b", k, a_if.i_0_last, (k == 3)); end
`endif
      next_cycle();
    end
    @(negedge clk);
    n_checks++; if (a_if.i_0_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle_valid: got %0b expected 0", a_if.i_0_valid); end
    n_checks++; if (a_if.t_0_ready !== 1'b1) begin n_fail++; $display("FAIL single_idle_tready: got %0b expected 1", a_if.t_0_ready); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    a_if.i_0_ready = 1'b1; a_if.t_0_valid = 1'b1; a_if.t_0_data = 32'h03020100;
    @(negedge clk);
    n_checks++; if (a_if.t_0_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_accept0: got %0b expected 1", a_if.t_0_ready); end
    next_cycle();
    a_if.t_0_data = 32'h07060504;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++; if (a_if.i_0_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %0b expected 1", k, a_if.i_0_valid); end
      n_checks++; if (a_if.i_0_data !== 8'(k)) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, a_if.i_0_data, 8'(k)); end
      n_checks++; if (a_if.t_0_ready !== ((k % 4) == 3)) begin n_fail++; $display("FAIL b2b_tready[%0d]: got %0b expected %0b", k, a_if.t_0_ready, ((k % 4) == 3)); end
`ifdef EB_DNSIZE_LAST_EN
      n_checks++; if (a_if.i_0_last !== ((k % 4) == 3)) begin n_fail++; $display("FAIL b2b_last[%0d]: got %0b expected %0b", k, a_if.i_0_last, ((k % 4) == 3)); end
`endif
      next_cycle();
      if (k == 3) begin
        a_if.t_0_valid = 1'b0; a_if.t_0_data = $urandom;
      end
    end
    @(negedge clk);
    n_checks++; if (a_if.i_0_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_valid: got %0b expected 0", a_if.i_0_valid); end
    next_cycle();
  endtask

  task automatic test_backpressure();
    logic [7:0] exp;
    a_if.i_0_ready = 1'b1; a_if.t_0_valid = 1'b1; a_if.t_0_data = 32'hDDCCBBAA;
    @(negedge clk);
    next_cycle();
    a_if.t_0_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (a_if.i_0_data !== 8'hAA) begin n_fail++; $display("FAIL bp_first: got %h expected aa", a_if.i_0_data); end
    next_cycle();
    // Stall with junk offered on the wide side; it must not be taken.
    a_if.i_0_ready = 1'b0; a_if.t_0_valid = 1'b1; a_if.t_0_data = $urandom;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (a_if.i_0_data !== 8'hBB) begin n_fail++; $display("FAIL bp_hold_data[%0d]: got %h expected bb", k, a_if.i_0_data); end
      n_checks++; if (a_if.i_0_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %0b expected 1", k, a_if.i_0_valid); end
      n_checks++; if (a_if.t_0_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_tready[%0d]: got %0b expected 0", k, a_if.t_0_ready); end
      next_cycle();
    end
    a_if.i_0_ready = 1'b1; a_if.t_0_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      exp = 8'(32'hDDCCBBAA >> (8 * k));
      n_checks++; if (a_if.i_0_data !== exp) begin n_fail++; $display("FAIL bp_resume_data[%0d]: got %h expected %h", k, a_if.i_0_data, exp); end
      n_checks++; if (a_if.t_0_ready !== (k == 3)) begin n_fail++; $display("FAIL bp_resume_tready[%0d]: got %0b expected %0b", k, a_if.t_0_ready, (k == 3)); end
      next_cycle();
    end
    @(negedge clk);
    n_checks++; if (a_if.i_0_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle_valid: got %0b expected 0", a_if.i_0_valid); end
    next_cycle();
  endtask

  task automatic test_reset_midword();
    logic [7:0] exp;
    a_if.i_0_ready = 1'b1; a_if.t_0_valid = 1'b1; a_if.t_0_data = 32'hDDCCBBAA;
    @(negedge clk);
    next_cycle();
    a_if.t_0_valid = 1'b0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    n_checks++; if (a_if.i_0_data !== 8'hBB) begin n_fail++; $display("FAIL midrst_bb: got %h expected bb", a_if.i_0_data); end
    next_cycle();
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    a_if.t_0_valid = 1'b1; a_if.t_0_data = 32'h44332211;
    @(negedge clk);
    n_checks++; if (a_if.i_0_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %0b expected 0", a_if.i_0_valid); end
    n_checks++; if (a_if.t_0_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_tready: got %0b expected 1", a_if.t_0_ready); end
    n_checks++; if (a_if.i_0_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h expected 00", a_if.i_0_data); end
`ifdef EB_DNSIZE_LAST_EN
    n_checks++; if (a_if.i_0_last !== 1'b0) begin n_fail++; $display("FAIL midrst_last: got %0b expected 0", a_if.i_0_last); end
`endif
    next_cycle();
    a_if.t_0_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp = 8'(32'h44332211 >> (8 * k));
      n_checks++; if (a_if.i_0_data !== exp) begin n_fail++; $display("FAIL midrst_next[%0d]: got %h expected %h", k, a_if.i_0_data, exp); end
      next_cycle();
    end
  endtask

  task automatic test_nonpow2();
    logic [7:0] exp;
    b_if.i_0_ready = 1'b1; b_if.t_0_valid = 1'b1; b_if.t_0_data = 24'h332211;
    @(negedge clk);
    n_checks++; if (b_if.t_0_ready !== 1'b1) begin n_fail++; $display("FAIL np2_accept0: got %0b expected 1", b_if.t_0_ready); end
    next_cycle();
    b_if.t_0_data = 24'h665544;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp = 8'(8'h11 * (k + 1));
      n_checks++; if (b_if.i_0_valid !== 1'b1) begin n_fail++; $display("FAIL np2_valid[%0d]: got %0b expected 1", k, b_if.i_0_valid); end
      n_checks++; if (b_if.i_0_data !== exp) begin n_fail++; $display("FAIL np2_data[%0d]: got %h expected %h", k, b_if.i_0_data, exp); end
      n_checks++; if (b_if.t_0_ready !== ((k % 3) == 2)) begin n_fail++; $display("FAIL np2_tready[%0d]: got %0b expected %0b", k, b_if.t_0_ready, ((k % 3) == 2)); end
      n_checks++; if (u_dut_b.u_ctrl.cnt === 2'd3) begin n_fail++; $display("FAIL np2_cnt[%0d]: got 3 required below 3", k); end
`ifdef EB_DNSIZE_LAST_EN
      n_checks++; if (b_if.i_0_last !== ((k % 3) == 2)) begin n_fail++; $display("FAIL np2_last[%0d]: got %0b expected %0b", k, b_if.i_0_last, ((k % 3) == 2)); end
`endif
      next_cycle();
      if (k == 2) b_if.t_0_valid = 1'b0;
    end
    @(negedge clk);
    n_checks++; if (b_if.i_0_valid !== 1'b0) begin n_fail++; $display("FAIL np2_idle_valid: got %0b expected 0", b_if.i_0_valid); end
    next_cycle();
  endtask

  // Model: a queue of beats still owed downstream, refilled whole-word when a word is accepted.
  task automatic test_random();
    logic [7:0] q[$];
    logic       exp_tready;
    logic       rst;
    for (int c = 0; c < 400; c++) begin
      a_if.t_0_valid = ($urandom_range(0, 9) < 6);
      a_if.t_0_data  = $urandom;
      a_if.i_0_ready = ($urandom_range(0, 9) < 7);
      rst            = ($urandom_range(0, 99) == 0);
      reset_n        = !rst;
      @(negedge clk);
      exp_tready = (q.size() == 0) || ((q.size() == 1) && a_if.i_0_ready);
      n_checks++; if (a_if.i_0_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %0b expected %0b", c, a_if.i_0_valid, (q.size() != 0)); end
      n_checks++; if (a_if.t_0_ready !== exp_tready) begin n_fail++; $display("FAIL rnd_tready[%0d]: got %0b expected %0b", c, a_if.t_0_ready, exp_tready); end
      if (q.size() != 0) begin
        n_checks++; if (a_if.i_0_data !== q[0]) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h expected %h", c, a_if.i_0_data, q[0]); end
      end
`ifdef EB_DNSIZE_LAST_EN
      n_checks++; if (a_if.i_0_last !== (q.size() == 1)) begin n_fail++; $display("FAIL rnd_last[%0d]: got %0b expected %0b", c, a_if.i_0_last, (q.size() == 1)); end
`endif
      if (rst) begin
        q.delete();
      end else begin
        if ((q.size() != 0) && a_if.i_0_ready) void'(q.pop_front());
        if (a_if.t_0_valid && exp_tready) begin
          for (int k = 0; k < 4; k++) q.push_back(8'(a_if.t_0_data >> (8 * k)));
        end
      end
      next_cycle();
    end
    reset_n = 1'b1;
    a_if.t_0_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    a_if.t_0_valid = 1'b0; a_if.t_0_data = '0; a_if.i_0_ready = 1'b0;
    b_if.t_0_valid = 1'b0; b_if.t_0_data = '0; b_if.i_0_ready = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_reset_midword();
    test_nonpow2();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/eb_dnsize.md
Name: eb_dnsize

Overview:
- Elastic width-down converter on the valid/ready fabric.
- Accepts one wide word on the target side and emits it as RATIO narrow beats on the initiator side, LSB-first.
- Sits directly downstream of a 2-deep elastic buffer stage, feeding narrow-datapath consumers.
- Sustains full throughput: a new wide word is accepted in the same cycle the last beat of the previous word is taken.

Parameters:
- T_0_WIDTH, 32, width of the wide input word; must be an integer multiple of I_0_WIDTH.
- I_0_WIDTH, 8, width of one output beat.
- RATIO (localparam), T_0_WIDTH/I_0_WIDTH, beats per word; must be >= 2. Elaboration error if violated.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  synchronous active-low reset.
- t_0_data  input  T_0_WIDTH  wide word in.
- t_0_valid  input  1  wide word present.
- t_0_ready  output  1  block accepts wide word this cycle.
- i_0_data  output  I_0_WIDTH  current narrow beat.
- i_0_valid  output  1  beat present.
- i_0_ready  input  1  downstream takes beat this cycle.

Behaviour:
- Reset: one clock, synchronous active-low reset (reset_n). Sampled only on the rising clk edge.
  - Registers after a reset edge: valid_q=0, cnt=0, hold register=0.
  - Resulting outputs: i_0_valid=0, i_0_data=0, t_0_ready=1.
- Reset mid-word: remaining beats are discarded. No partial beat is emitted after reset.
- Transfer rule: a transfer occurs on either side only when valid && ready at the clock edge.
- State encoding: valid_q (EMPTY=0 / BUSY=1) plus beat counter cnt, width $clog2(RATIO).
- last = valid_q && (cnt == RATIO-1).
- t_0_ready = !valid_q || (last && i_0_ready). Combinational; no combinational path from t_0_valid.
- i_0_valid = valid_q, registered.
- i_0_data = hold[cnt*I_0_WIDTH +: I_0_WIDTH].
- Output valid/data stay stable while i_0_valid && !i_0_ready.
- Transitions:
  - EMPTY, t_0 transfer: load hold, cnt=0, go BUSY.
  - BUSY, i_0 transfer, !last: cnt++.
  - BUSY, i_0 transfer, last, t_0 transfer in the same cycle: load new hold, cnt=0, stay BUSY (back-to-back, no bubble).
  - BUSY, i_0 transfer, last, no t_0 transfer: cnt=0, go EMPTY.
  - BUSY, no i_0 transfer: hold everything.
- Latency: the first beat appears on i_0 one cycle after the t_0 transfer.
- Throughput: one beat per cycle when i_0_ready=1. t_0 accepts one word every RATIO cycles.
- cnt wrap: cnt never exceeds RATIO-1, including for non-power-of-2 RATIO.
- t_0_data is ignored when not transferring. The hold register changes only on a t_0 transfer.

Optional Feature:
- Macro: EB_DNSIZE_LAST_EN.
- Defined:
  - Extra output port i_0_last (1 bit), equal to last.
  - i_0_last is 0 when i_0_valid=0 and during reset.
  - Downstream uses it to delimit words.
- Undefined: no i_0_last port. Behaviour is otherwise identical.

Decomposition:
- Shared package eb_pkg:
  - function eb_clog2-style width helper for the counter.
  - localparam checks for the RATIO constraint.
  - state enum typedef eb_state_t {EB_EMPTY, EB_BUSY}.
- One natural sub-module: eb_dnsize_ctrl.
  - Owns valid_q, cnt, t_0_ready, i_0_valid, last.
  - Outputs en_load and sel (= cnt).
- The top level holds the hold register and the beat mux, mirroring the team's data/ctrl split.

Test Plan:
- Single word: after reset, T=32/I=8, send 0xDDCCBBAA with i_0_ready=1 -> beats 0xAA,0xBB,0xCC,0xDD on 4 consecutive cycles starting 1 cycle after accept; t_0_ready low for cycles 2-4 relative to accept.
- Back-to-back: t_0_valid held high with words 0x03020100, 0x07060504 -> beats 0x00..0x07 on 8 consecutive cycles with no bubble; second accept coincides with beat 0x03.
- Backpressure: i_0_ready=0 for 3 cycles while beat 0xBB is presented -> i_0_data stays 0xBB and t_0_ready stays 0; beat 0xCC follows the cycle after i_0_ready rises.
- Reset mid-word: assert reset_n=0 for one edge after beat 0xBB is taken -> next cycle i_0_valid=0, t_0_ready=1; the next word 0x44332211 emits 0x11 first.
- Non-power-of-2: T=24/I=8, words 0x332211 and 0x665544 -> beats 0x11,0x22,0x33,0x44,0x55,0x66; cnt never equals 3.
- With EB_DNSIZE_LAST_EN: in scenario 2, i_0_last is 1 exactly on beats 0x03 and 0x07, and 0 otherwise.
